// File: rtl/rename_pkg.sv
// rename_pkg: shared rename-stage widths, sizes and register/tag types.
package rename_pkg;
  localparam int PREG_WIDTH = 7;
  localparam int ROB_WIDTH  = 4;
  localparam int NUM_AREGS  = 32;
  localparam int NUM_PREGS  = 1 << PREG_WIDTH;
  localparam int NUM_TAGS   = 1 << ROB_WIDTH;
  localparam int NUM_FREE   = NUM_PREGS - NUM_AREGS;
  typedef logic [PREG_WIDTH-1:0] preg_t;
  typedef logic [ROB_WIDTH-1:0]  rob_tag_t;
  typedef logic [PREG_WIDTH:0]   cnt_t;
endpackage

// File: rtl/fl_snapshot_table.sv
// fl_snapshot_table: per-ROB-tag read-pointer snapshots, one write port, async read.
module fl_snapshot_table
  import rename_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     we,
  input  rob_tag_t waddr,
  input  preg_t    wdata,
  input  rob_tag_t raddr,
  output preg_t    rdata
);
  preg_t snap [NUM_TAGS];
  assign rdata = snap[raddr];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) snap[i] <= '0;
    end else if (we) begin
      snap[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical registers with one-cycle mispredict restore.
// Optional FREE_LIST_CHECK_EN adds an allocation bitmap and sticky o_err.
module free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_dispatch_valid,
  input  rob_tag_t            i_dispatch_tag,
  input  logic                i_reg_write,
  output logic                o_alloc_valid,
  output preg_t               o_alloc_preg,
  input  logic                i_commit_valid,
  input  preg_t               i_commit_old_preg,
  input  logic                i_flush,
  input  rob_tag_t            i_flush_tag,
  output logic [PREG_WIDTH:0] o_count
`ifdef FREE_LIST_CHECK_EN
  , output logic              o_err
`endif
);
  preg_t mem [NUM_PREGS];
  preg_t rd_ptr, wr_ptr, snap_preg, rd_next;
  cnt_t  count;
  logic  pop, push;
  assign o_alloc_valid = count != '0;
  assign o_alloc_preg  = mem[rd_ptr];
  assign o_count       = count;
  assign pop     = i_dispatch_valid && i_reg_write && o_alloc_valid && !i_flush;
  assign push    = i_commit_valid && i_commit_old_preg != '0;
  assign rd_next = rd_ptr + preg_t'(pop);
  fl_snapshot_table u_snap (
    .clk   (clk),
    .reset (reset),
    .we    (i_dispatch_valid && !i_flush),
    .waddr (i_dispatch_tag),
    .wdata (rd_next),
    .raddr (i_flush_tag),
    .rdata (snap_preg)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) mem[i] <= (i < NUM_FREE) ? preg_t'(NUM_AREGS + i) : '0;
      rd_ptr <= '0;
      wr_ptr <= preg_t'(NUM_FREE);
      count  <= cnt_t'(NUM_FREE);
    end else begin
      if (push) begin
        mem[wr_ptr] <= i_commit_old_preg;
        wr_ptr      <= wr_ptr + preg_t'(1);
      end
      // count never reaches 2^PREG_WIDTH, so the wrapped distance is exact
      if (i_flush) begin
        rd_ptr <= snap_preg;
        count  <= {1'b0, wr_ptr + preg_t'(push) - snap_preg};
      end else begin
        rd_ptr <= rd_next;
        count  <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end
`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PREGS-1:0] alloc;
  logic bad;
  assign bad = (push && (!alloc[i_commit_old_preg] || count == cnt_t'(NUM_FREE)))
            || (i_dispatch_valid && i_reg_write && !o_alloc_valid && !i_flush);
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc <= {{NUM_FREE{1'b0}}, {NUM_AREGS{1'b1}}};
      o_err <= 1'b0;
    end else begin
      if (pop) alloc[o_alloc_preg] <= 1'b1;
      if (push) alloc[i_commit_old_preg] <= 1'b0;
      o_err <= o_err || bad;
    end
  end
`endif
endmodule
